// File: rtl/mem_stage_pipelined.sv
// mem_stage_pipelined: RV32I MEM stage with sized/sign-extended loads and stores,
// configurable wait states with stall request, misalign detection and a MEM/WB register.
module mem_stage_pipelined #(
  parameter int XLEN = 32,
  parameter int DEPTH = 256,
  parameter int LATENCY = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ValidM,
  input  logic            RegWriteM,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic [4:0]      RdM,
  input  logic [1:0]      ResultSrcM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic            FlushW,
  output logic            StallM,
  output logic            MisalignM,
  output logic            ValidW,
  output logic            RegWriteW,
  output logic [4:0]      RdW,
  output logic [1:0]      ResultSrcW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] LAT = 3'(LATENCY);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [4:0]      rd;
    logic [1:0]      result_src;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] pc4;
  } w_t;
  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic            legal, mem_op, bad, access, done;
  logic [XLEN-1:0] word, ld_data, st_data, wr_word;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [3:0]      be;
  logic [0:0]      state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  w_t              w_q, w_d;
  assign idx  = ALUResultM[AW+1:2];
  assign lane = ALUResultM[1:0];
  always_comb begin
    legal     = Funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    mem_op    = ValidM & (MemReadM | MemWriteM);
    MisalignM = mem_op & (((Funct3M[1:0] == 2'b01) & lane[0]) | ((Funct3M == 3'b010) & (lane != 2'b00)));
    bad       = mem_op & (MisalignM | ~legal);
    access    = mem_op & ~bad;
    word      = mem[idx];
    ld_b      = word[8*lane +: 8];
    ld_h      = word[16*lane[1] +: 16];
    ld_data   = (Funct3M[1:0] == 2'b00) ? {{(XLEN-8){ld_b[7] & ~Funct3M[2]}}, ld_b} :
                (Funct3M[1:0] == 2'b01) ? {{(XLEN-16){ld_h[15] & ~Funct3M[2]}}, ld_h} : word;
    be        = (Funct3M[1:0] == 2'b00) ? 4'b0001 << lane :
                (Funct3M[1:0] == 2'b01) ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    st_data   = (Funct3M[1:0] == 2'b00) ? {4{WriteDataM[7:0]}} :
                (Funct3M[1:0] == 2'b01) ? {2{WriteDataM[15:0]}} : WriteDataM;
    for (int i = 0; i < 4; i++) wr_word[8*i +: 8] = be[i] ? st_data[8*i +: 8] : word[8*i +: 8];
  end
  // Wait-state FSM: the access completes on the cycle cnt reaches LATENCY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    StallM  = 1'b0;
    done    = access;
    if (LATENCY != 0) begin
      done = 1'b0;
      if (state_q == IDLE) begin
        if (access) begin
          StallM  = 1'b1;
          cnt_d   = 3'd1;
          state_d = WAIT;
        end
      end else if (cnt_q == LAT) begin
        done    = access;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        StallM = 1'b1;
        cnt_d  = cnt_q + 3'd1;
      end
    end
  end
  always_comb begin
    w_d = '{valid: ValidM, reg_write: RegWriteM & ~bad, rd: RdM, result_src: ResultSrcM,
            alu: ALUResultM, rdata: (done & MemReadM) ? ld_data : '0, pc4: PCPlus4M};
    if (StallM) begin
      w_d           = w_q;
      w_d.valid     = 1'b0;
      w_d.reg_write = 1'b0;
    end
    if (FlushW) w_d = '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
    end
  end
  // Memory is never cleared; reset only suppresses a write in flight.
  always_ff @(posedge clk) begin
    if (done & MemWriteM & ~reset) mem[idx] <= wr_word;
  end
  assign ValidW     = w_q.valid;
  assign RegWriteW  = w_q.reg_write;
  assign RdW        = w_q.rd;
  assign ResultSrcW = w_q.result_src;
  assign ALUResultW = w_q.alu;
  assign ReadDataW  = w_q.rdata;
  assign PCPlus4W   = w_q.pc4;
endmodule

// File: tb/tb_mem_stage_pipelined.sv
// tb_mem_stage_pipelined: vector table on a zero-latency instance plus wait-state,
// reset-abort and wrap sequences on a three-wait-state instance, with a scoreboard queue.
module tb_mem_stage_pipelined;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic        ValidM, RegWriteM, MemReadM, MemWriteM, FlushW;
  logic [2:0]  Funct3M;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic        s0, m0, v0, rw0, s3, m3, v3, rw3;
  logic [4:0]  rd0, rd3;
  logic [1:0]  rs0, rs3;
  logic [31:0] alu0, rdat0, pc0, alu3, rdat3, pc3;
  mem_stage_pipelined #(.XLEN(32), .DEPTH(256), .LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .ValidM(ValidM), .RegWriteM(RegWriteM), .MemReadM(MemReadM),
    .MemWriteM(MemWriteM), .Funct3M(Funct3M), .RdM(RdM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .FlushW(FlushW),
    .StallM(s0), .MisalignM(m0), .ValidW(v0), .RegWriteW(rw0), .RdW(rd0), .ResultSrcW(rs0),
    .ALUResultW(alu0), .ReadDataW(rdat0), .PCPlus4W(pc0));
  mem_stage_pipelined #(.XLEN(32), .DEPTH(256), .LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .ValidM(ValidM), .RegWriteM(RegWriteM), .MemReadM(MemReadM),
    .MemWriteM(MemWriteM), .Funct3M(Funct3M), .RdM(RdM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .FlushW(FlushW),
    .StallM(s3), .MisalignM(m3), .ValidW(v3), .RegWriteW(rw3), .RdW(rd3), .ResultSrcW(rs3),
    .ALUResultW(alu3), .ReadDataW(rdat3), .PCPlus4W(pc3));
  typedef struct {
    logic        valid, rw, mr, mw, flush;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr, wdata;
    logic        ev, erw, emis;
    logic [31:0] erd;
  } vec_t;
  typedef struct {
    logic        v, rw;
    logic [4:0]  rd;
    logic [1:0]  rs;
    logic [31:0] alu, rdat, pc4;
  } exp_t;
  vec_t vt[$];
  exp_t q[$];
  int total = 0;
  int bad = 0;
  function automatic vec_t mk(input logic valid, rw, mr, mw, input logic [2:0] f3, input logic [4:0] rd,
                              input logic [31:0] addr, wdata, input logic flush, ev, erw, emis,
                              input logic [31:0] erd);
    vec_t v;
    v.valid = valid; v.rw = rw; v.mr = mr; v.mw = mw; v.f3 = f3; v.rd = rd; v.addr = addr;
    v.wdata = wdata; v.flush = flush; v.ev = ev; v.erw = erw; v.emis = emis; v.erd = erd;
    return v;
  endfunction
  function automatic exp_t model(input vec_t v);
    exp_t e;
    e.v = v.ev; e.rw = v.erw; e.rdat = v.erd;
    e.rd  = v.flush ? 5'd0 : v.rd;
    e.rs  = v.flush ? 2'd0 : v.rd[1:0];
    e.alu = v.flush ? 32'd0 : v.addr;
    e.pc4 = v.flush ? 32'd0 : v.addr + 32'd4;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  task automatic apply(input vec_t v);
    ValidM = v.valid; RegWriteM = v.rw; MemReadM = v.mr; MemWriteM = v.mw; Funct3M = v.f3;
    RdM = v.rd; ResultSrcM = v.rd[1:0]; ALUResultM = v.addr; WriteDataM = v.wdata;
    PCPlus4M = v.addr + 32'd4; FlushW = v.flush;
  endtask
  task automatic idle();
    apply(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask
  task automatic lat_run(input vec_t v, input string nm);
    exp_t e;
    int   stalls, edges;
    bit   got;
    apply(v);
    q.push_back(model(v));
    stalls = 0; edges = 0; got = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      #1;
      if (s3) stalls++;
      @(posedge clk); #1;
      edges++;
      if (v3) got = 1;
    end
    e = q.pop_front();
    chk({nm, "_done"}, 32'(got), 32'd1);
    chk({nm, "_stalls"}, stalls, 3);
    chk({nm, "_edges"}, edges, 4);
    chk({nm, "_rw"}, rw3, e.rw);
    chk({nm, "_rd"}, rd3, e.rd);
    chk({nm, "_rdata"}, rdat3, e.rdat);
  endtask
  initial begin
    exp_t e;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {v0, v3}, 0);
    chk("rst_rw", {rw0, rw3}, 0);
    chk("rst_rd", {rd0, rd3}, 0);
    chk("rst_alu", alu0 | alu3, 0);
    chk("rst_rdata", rdat0 | rdat3, 0);
    chk("rst_pc", pc0 | pc3, 0);
    chk("rst_stall", {s0, s3}, 0);
    reset = 1'b0;
    //      val rw mr mw f3      rd addr           wdata          fl ev erw mis erd
    vt.push_back(mk(1, 0, 0, 1, 3'b010, 1, 32'h10,  32'hDEADBEEF, 0, 1, 0, 0, 32'h0));
    vt.push_back(mk(1, 1, 1, 0, 3'b010, 2, 32'h10,  32'h0,        0, 1, 1, 0, 32'hDEADBEEF));
    vt.push_back(mk(1, 0, 0, 1, 3'b000, 3, 32'h13,  32'h12345680, 0, 1, 0, 0, 32'h0));
    vt.push_back(mk(1, 1, 1, 0, 3'b000, 4, 32'h13,  32'h0,        0, 1, 1, 0, 32'hFFFFFF80));
    vt.push_back(mk(1, 1, 1, 0, 3'b100, 5, 32'h13,  32'h0,        0, 1, 1, 0, 32'h00000080));
    vt.push_back(mk(1, 1, 1, 0, 3'b010, 6, 32'h10,  32'h0,        0, 1, 1, 0, 32'h80ADBEEF));
    vt.push_back(mk(1, 1, 1, 0, 3'b001, 7, 32'h11,  32'h0,        0, 1, 0, 1, 32'h0));
    vt.push_back(mk(1, 0, 0, 1, 3'b010, 8, 32'h14,  32'hCAFEF00D, 0, 1, 0, 0, 32'h0));
    vt.push_back(mk(1, 0, 0, 1, 3'b010, 9, 32'h16,  32'h11111111, 0, 1, 0, 1, 32'h0));
    vt.push_back(mk(1, 1, 1, 0, 3'b010, 10, 32'h14, 32'h0,        0, 1, 1, 0, 32'hCAFEF00D));
    vt.push_back(mk(1, 1, 1, 0, 3'b001, 11, 32'h16, 32'h0,        0, 1, 1, 0, 32'hFFFFCAFE));
    vt.push_back(mk(1, 1, 1, 0, 3'b101, 12, 32'h14, 32'h0,        0, 1, 1, 0, 32'h0000F00D));
    vt.push_back(mk(1, 0, 0, 1, 3'b010, 13, 32'h18, 32'h0,        0, 1, 0, 0, 32'h0));
    vt.push_back(mk(1, 0, 0, 1, 3'b001, 14, 32'h1A, 32'h0000BEEF, 0, 1, 0, 0, 32'h0));
    vt.push_back(mk(1, 1, 1, 0, 3'b010, 15, 32'h18, 32'h0,        0, 1, 1, 0, 32'hBEEF0000));
    vt.push_back(mk(1, 1, 1, 0, 3'b011, 16, 32'h10, 32'h0,        0, 1, 0, 0, 32'h0));
    vt.push_back(mk(1, 1, 0, 0, 3'b000, 17, 32'h12345678, 32'h0,  0, 1, 1, 0, 32'h0));
    vt.push_back(mk(1, 0, 0, 1, 3'b010, 18, 32'h400, 32'h0BADF00D, 0, 1, 0, 0, 32'h0));
    vt.push_back(mk(1, 1, 1, 0, 3'b010, 19, 32'h000, 32'h0,       0, 1, 1, 0, 32'h0BADF00D));
    vt.push_back(mk(1, 1, 1, 1, 3'b010, 20, 32'h10, 32'h55555555, 0, 1, 1, 0, 32'h80ADBEEF));
    vt.push_back(mk(1, 1, 1, 0, 3'b010, 21, 32'h10, 32'h0,        0, 1, 1, 0, 32'h55555555));
    vt.push_back(mk(0, 0, 0, 0, 3'b000, 22, 32'h30, 32'h0,        0, 0, 0, 0, 32'h0));
    vt.push_back(mk(1, 0, 0, 1, 3'b010, 23, 32'h20, 32'h77777777, 1, 0, 0, 0, 32'h0));
    vt.push_back(mk(1, 1, 1, 0, 3'b010, 24, 32'h20, 32'h0,        0, 1, 1, 0, 32'h77777777));
    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i]);
      #1;
      chk($sformatf("v%0d_stall", i), s0, 0);
      chk($sformatf("v%0d_mis", i), m0, vt[i].emis);
      q.push_back(model(vt[i]));
      @(posedge clk); #1;
      e = q.pop_front();
      chk($sformatf("v%0d_valid", i), v0, e.v);
      chk($sformatf("v%0d_rw", i), rw0, e.rw);
      chk($sformatf("v%0d_rd", i), rd0, e.rd);
      chk($sformatf("v%0d_rs", i), rs0, e.rs);
      chk($sformatf("v%0d_alu", i), alu0, e.alu);
      chk($sformatf("v%0d_rdata", i), rdat0, e.rdat);
      chk($sformatf("v%0d_pc", i), pc0, e.pc4);
    end
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    lat_run(mk(1, 0, 0, 1, 3'b010, 1, 32'h40, 32'hA5A5A5A5, 0, 1, 0, 0, 32'h0), "l3_sw");
    lat_run(mk(1, 1, 1, 0, 3'b010, 2, 32'h40, 32'h0, 0, 1, 1, 0, 32'hA5A5A5A5), "l3_lw");
    apply(mk(1, 1, 0, 0, 3'b000, 3, 32'h99, 32'h0, 0, 1, 1, 0, 32'h0));
    #1;
    chk("l3_nomem_stall", s3, 0);
    @(posedge clk); #1;
    chk("l3_nomem_valid", v3, 1);
    chk("l3_nomem_alu", alu3, 32'h99);
    lat_run(mk(1, 1, 1, 0, 3'b000, 4, 32'h41, 32'h0, 0, 1, 1, 0, 32'hFFFFFFA5), "l3_lb");
    lat_run(mk(1, 0, 0, 1, 3'b010, 5, 32'h44, 32'h12121212, 0, 1, 0, 0, 32'h0), "l3_sw44");
    apply(mk(1, 0, 0, 1, 3'b010, 6, 32'h44, 32'hFFFFFFFF, 0, 1, 0, 0, 32'h0));
    @(posedge clk); #1;
    chk("l3_wait_stall", s3, 1);
    chk("l3_wait_bubble", v3, 0);
    reset = 1'b1;
    idle();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("l3_rst_stall", s3, 0);
    chk("l3_rst_w", {v3, rw3, rd3, rs3}, 0);
    chk("l3_rst_alu", alu3 | rdat3 | pc3, 0);
    lat_run(mk(1, 1, 1, 0, 3'b010, 7, 32'h44, 32'h0, 0, 1, 1, 0, 32'h12121212), "l3_abort");
    lat_run(mk(1, 0, 0, 1, 3'b010, 8, 32'h800, 32'h600DCAFE, 0, 1, 0, 0, 32'h0), "l3_wrap_sw");
    lat_run(mk(1, 1, 1, 0, 3'b010, 9, 32'h000, 32'h0, 0, 1, 1, 0, 32'h600DCAFE), "l3_wrap_lw");
    apply(mk(1, 1, 1, 0, 3'b001, 10, 32'h43, 32'h0, 0, 1, 0, 1, 32'h0));
    #1;
    chk("l3_mis_flag", m3, 1);
    chk("l3_mis_stall", s3, 0);
    @(posedge clk); #1;
    chk("l3_mis_w", {v3, rw3}, 2'b10);
    idle();
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
